bus_power_init_sequencer: RTL and testbench

Sequences power-up and oscillator trimming of the CAN buses behind `mopshub_top_16bus`, one bus at a time, before the hub starts normal traffic. On a start request it steps a bus counter from 0 to the configured last bus. For each bus it issues a power-enable strobe, waits a settle interval, and optionally runs an oscillator-trim handshake. It then raises `end_power_init` so the initialization state machine can proceed to sign-on.

---
 rtl/bus_power_init_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_bus_power_init_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_power_init_sequencer.sv
// bus_power_init_sequencer
//   Powers up the CAN buses behind the 16-bus hub one at a time. For each bus it
//   issues a power-enable strobe, waits SETTLE_CYCLES clocks and, when trim_en
//   is high at the end of the settle interval, runs an oscillator-trim handshake.
//   After the last bus it pulses end_power_init.
//
//   Optional feature macro: BUS_TRIM_TIMEOUT_EN. When it is defined, the trim
//   handshake is bounded by TRIM_TIMEOUT cycles and an expiry sets the sticky
//   trim_timeout_err. When it is undefined, the wait for end_trim_bus is
//   unbounded and trim_timeout_err is tied low.
//
// Ports
//   clk              in   hub clock (40 MHz)
//   rst              in   asynchronous reset, active low
//   start_init       in   start request, sampled only while idle
//   n_buses[4:0]     in   index of the last bus, clamped to 15, latched at start
//   trim_en          in   trim enable, sampled on the final settle cycle
//   end_trim_bus     in   trim-done pulse, honoured only while waiting for trim
//   power_bus_en     out  one-cycle power strobe per bus
//   power_bus_cnt    out  current bus index (0..15)
//   start_trim       out  one-cycle trim request
//   bus_on_mask      out  bit i set once bus i has been strobed
//   busy             out  high while a sequence is in progress
//   end_power_init   out  one-cycle completion pulse
//   trim_timeout_err out  sticky trim timeout flag, cleared on the next start

module bus_power_init_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned TRIM_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_init,
    input  logic [4:0]  n_buses,
    input  logic        trim_en,
    input  logic        end_trim_bus,
    output logic        power_bus_en,
    output logic [4:0]  power_bus_cnt,
    output logic        start_trim,
    output logic [15:0] bus_on_mask,
    output logic        busy,
    output logic        end_power_init,
    output logic        trim_timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        POWER_ON,
        SETTLE,
        TRIM_REQ,
        TRIM_WAIT,
        NEXT,
        DONE
    } state_t;

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt, settle_cnt_nxt;
    logic [3:0]      last, last_nxt;
    logic [4:0]      cnt_nxt;
    logic [15:0]     mask_nxt;

`ifdef BUS_TRIM_TIMEOUT_EN
    localparam int unsigned TW = (TRIM_TIMEOUT > 1) ? $clog2(TRIM_TIMEOUT) : 1;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic            err_nxt;
`else
    logic            unused_trim_timeout;
    assign unused_trim_timeout = (TRIM_TIMEOUT != 0);
    assign trim_timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        last_nxt       = last;
        cnt_nxt        = power_bus_cnt;
        mask_nxt       = bus_on_mask;
`ifdef BUS_TRIM_TIMEOUT_EN
        tmo_cnt_nxt    = tmo_cnt;
        err_nxt        = trim_timeout_err;
`endif
        case (state)
            IDLE: begin
                if (start_init) begin
                    last_nxt  = n_buses[4] ? 4'd15 : n_buses[3:0];
                    cnt_nxt   = '0;
                    mask_nxt  = '0;
`ifdef BUS_TRIM_TIMEOUT_EN
                    err_nxt   = 1'b0;
`endif
                    state_nxt = POWER_ON;
                end
            end
            POWER_ON: begin
                mask_nxt       = bus_on_mask | (16'd1 << power_bus_cnt[3:0]);
                settle_cnt_nxt = SW'(SETTLE_CYCLES - 1);
                state_nxt      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = trim_en ? TRIM_REQ : NEXT;
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end
            TRIM_REQ: begin
`ifdef BUS_TRIM_TIMEOUT_EN
                tmo_cnt_nxt = TW'(TRIM_TIMEOUT - 1);
`endif
                state_nxt   = TRIM_WAIT;
            end
            TRIM_WAIT: begin
                // a done pulse in the expiry cycle takes priority over the timeout
                if (end_trim_bus) begin
                    state_nxt = NEXT;
                end
`ifdef BUS_TRIM_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = NEXT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - 1'b1;
                end
`endif
            end
            NEXT: begin
                if (power_bus_cnt[3:0] == last) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = power_bus_cnt + 5'd1;
                    state_nxt = POWER_ON;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // strobes and busy are registered from the next state so they line up
    // with the cycle the FSM actually spends in the corresponding state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt     <= '0;
            last           <= '0;
            power_bus_cnt  <= '0;
            bus_on_mask    <= '0;
            power_bus_en   <= 1'b0;
            start_trim     <= 1'b0;
            end_power_init <= 1'b0;
            busy           <= 1'b0;
        end else begin
            settle_cnt     <= settle_cnt_nxt;
            last           <= last_nxt;
            power_bus_cnt  <= cnt_nxt;
            bus_on_mask    <= mask_nxt;
            power_bus_en   <= (state_nxt == POWER_ON);
            start_trim     <= (state_nxt == TRIM_REQ);
            end_power_init <= (state_nxt == DONE);
            busy           <= (state_nxt != IDLE);
        end
    end

`ifdef BUS_TRIM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt          <= '0;
            trim_timeout_err <= 1'b0;
        end else begin
            tmo_cnt          <= tmo_cnt_nxt;
            trim_timeout_err <= err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bus_power_init_sequencer.sv
module tb_bus_power_init_sequencer;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_init = 1'b0;
    logic [4:0]  n_buses = '0;
    logic        trim_en = 1'b0;
    logic        model_trim = 1'b0;
    logic        stray_trim = 1'b0;
    logic        end_trim_bus;
    logic        power_bus_en;
    logic [4:0]  power_bus_cnt;
    logic        start_trim;
    logic [15:0] bus_on_mask;
    logic        busy;
    logic        end_power_init;
    logic        trim_timeout_err;

    assign end_trim_bus = model_trim | stray_trim;

    bus_power_init_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TRIM_TIMEOUT  (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_init       (start_init),
        .n_buses          (n_buses),
        .trim_en          (trim_en),
        .end_trim_bus     (end_trim_bus),
        .power_bus_en     (power_bus_en),
        .power_bus_cnt    (power_bus_cnt),
        .start_trim       (start_trim),
        .bus_on_mask      (bus_on_mask),
        .busy             (busy),
        .end_power_init   (end_power_init),
        .trim_timeout_err (trim_timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int strobes, seq_err, spacing_err, trims, trim_lat_err, dones;
    int done_cyc, last_strobe, max_cnt, exp_idx, exp_spacing;
    int strobe_cyc[16];
    int resp_delay[16];
    int tcnt = 0;

    // activity monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (power_bus_en) begin
            if (int'(power_bus_cnt) != exp_idx) seq_err++;
            if (last_strobe >= 0 && exp_spacing != 0 && (cyc - last_strobe) != exp_spacing)
                spacing_err++;
            if (strobes < 16) strobe_cyc[strobes] = cyc;
            strobes++;
            exp_idx++;
            last_strobe = cyc;
            if (int'(power_bus_cnt) > max_cnt) max_cnt = int'(power_bus_cnt);
        end
        if (start_trim) begin
            trims++;
            if ((cyc - last_strobe) != int'(SETTLE + 1)) trim_lat_err++;
        end
        if (end_power_init) begin
            dones++;
            done_cyc = cyc;
        end
    end

    // trim engine model: answers resp_delay[bus] cycles after start_trim (0 = silent)
    always @(negedge clk) begin
        model_trim = 1'b0;
        if (tcnt != 0) begin
            tcnt--;
            if (tcnt == 0) model_trim = 1'b1;
        end
        if (start_trim) tcnt = resp_delay[power_bus_cnt[3:0]];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_stats();
        strobes = 0; seq_err = 0; spacing_err = 0; trims = 0; trim_lat_err = 0;
        dones = 0; done_cyc = 0; last_strobe = -1; max_cnt = 0; exp_idx = 0;
        for (int i = 0; i < 16; i++) strobe_cyc[i] = 0;
    endtask

    task automatic start_seq(input logic [4:0] nb, input logic te, input string tag);
        @(negedge clk);
        n_buses = nb;
        trim_en = te;
        clear_stats();
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        chk({tag, "_busy_rise"}, int'(busy), 1);
        chk({tag, "_err_clr"}, int'(trim_timeout_err), 0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int  i = 0;
        bit  seen = 1'b0;
        while (!seen && i < budget) begin
            @(negedge clk);
            i++;
            if (end_power_init) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        chk({tag, "_busy_fall"}, int'(busy), 0);
        chk({tag, "_done_1cyc"}, int'(end_power_init), 0);
    endtask

    task automatic wait_strobe(input int idx, input int budget, input string tag);
        int  i = 0;
        bit  seen = (power_bus_en && int'(power_bus_cnt) == idx);
        while (!seen && i < budget) begin
            @(negedge clk);
            i++;
            if (power_bus_en && int'(power_bus_cnt) == idx) seen = 1'b1;
        end
        chk({tag, "_strobe_seen"}, int'(seen), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) resp_delay[i] = 10;
        clear_stats();
        exp_spacing = 6;

        repeat (3) @(negedge clk);
        chk("rst_power_bus_en", int'(power_bus_en), 0);
        chk("rst_power_bus_cnt", int'(power_bus_cnt), 0);
        chk("rst_start_trim", int'(start_trim), 0);
        chk("rst_bus_on_mask", int'(bus_on_mask), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_end_power_init", int'(end_power_init), 0);
        chk("rst_trim_timeout_err", int'(trim_timeout_err), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 16 buses without trim: 1 + 4 + 1 = 6 cycles per bus
        exp_spacing = 6;
        start_seq(5'd15, 1'b0, "t1");
        wait_done(400, "t1");
        chk("t1_strobes", strobes, 16);
        chk("t1_seq", seq_err, 0);
        chk("t1_spacing", spacing_err, 0);
        chk("t1_trims", trims, 0);
        chk("t1_mask", int'(bus_on_mask), 32'hFFFF);
        chk("t1_cnt_hold", int'(power_bus_cnt), 15);
        chk("t1_dones", dones, 1);
        chk("t1_done_lat", done_cyc - last_strobe, 6);

        // 3 buses with trim answered after 10 cycles: 1 + 4 + 1 + 10 + 1 = 17
        exp_spacing = 17;
        start_seq(5'd2, 1'b1, "t2");
        wait_done(400, "t2");
        chk("t2_strobes", strobes, 3);
        chk("t2_trims", trims, 3);
        chk("t2_trim_lat", trim_lat_err, 0);
        chk("t2_spacing", spacing_err, 0);
        chk("t2_mask", int'(bus_on_mask), 32'h0007);
        chk("t2_err", int'(trim_timeout_err), 0);
        chk("t2_dones", dones, 1);

        // out-of-range bus count clamps to 15
        exp_spacing = 6;
        start_seq(5'd31, 1'b0, "t3");
        wait_done(400, "t3");
        chk("t3_strobes", strobes, 16);
        chk("t3_max_cnt", max_cnt, 15);
        chk("t3_seq", seq_err, 0);
        chk("t3_mask", int'(bus_on_mask), 32'hFFFF);

        // single bus
        start_seq(5'd0, 1'b0, "t4");
        wait_done(100, "t4");
        chk("t4_strobes", strobes, 1);
        chk("t4_mask", int'(bus_on_mask), 32'h0001);
        chk("t4_cnt", int'(power_bus_cnt), 0);
        chk("t4_dones", dones, 1);

        // restart requests and stray trim-done while settling are ignored
        exp_spacing = 17;
        start_seq(5'd3, 1'b1, "t5");
        for (int b = 0; b < 2; b++) begin
            wait_strobe(b, 100, "t5");
            @(negedge clk);
            stray_trim = 1'b1;
            start_init = 1'b1;
            @(negedge clk);
            stray_trim = 1'b0;
            start_init = 1'b0;
        end
        wait_done(400, "t5");
        chk("t5_strobes", strobes, 4);
        chk("t5_seq", seq_err, 0);
        chk("t5_spacing", spacing_err, 0);
        chk("t5_trims", trims, 4);
        chk("t5_dones", dones, 1);
        chk("t5_mask", int'(bus_on_mask), 32'h000F);

`ifdef BUS_TRIM_TIMEOUT_EN
        // bus 1 trim never answers: wait capped at 20 cycles, bus 2 still powered
        exp_spacing = 0;
        resp_delay[1] = 0;
        start_seq(5'd2, 1'b1, "t6a");
        wait_done(600, "t6a");
        chk("t6a_err", int'(trim_timeout_err), 1);
        chk("t6a_mask", int'(bus_on_mask), 32'h0007);
        chk("t6a_strobes", strobes, 3);
        chk("t6a_trims", trims, 3);
        chk("t6a_wait_len", strobe_cyc[2] - strobe_cyc[1], 27);

        // answer lands in the expiry cycle: success, no error
        resp_delay[1] = 20;
        start_seq(5'd2, 1'b1, "t6b");
        wait_done(600, "t6b");
        chk("t6b_err", int'(trim_timeout_err), 0);
        chk("t6b_wait_len", strobe_cyc[2] - strobe_cyc[1], 27);
        chk("t6b_mask", int'(bus_on_mask), 32'h0007);
        resp_delay[1] = 10;
`endif

        // asynchronous reset during bus 5 settle
        exp_spacing = 6;
        start_seq(5'd15, 1'b0, "t7");
        wait_strobe(5, 200, "t7");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_power_bus_en", int'(power_bus_en), 0);
        chk("t7_rst_cnt", int'(power_bus_cnt), 0);
        chk("t7_rst_start_trim", int'(start_trim), 0);
        chk("t7_rst_mask", int'(bus_on_mask), 0);
        chk("t7_rst_busy", int'(busy), 0);
        chk("t7_rst_end_power_init", int'(end_power_init), 0);
        chk("t7_rst_err", int'(trim_timeout_err), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_no_done", dones, 0);
        chk("t7_idle_busy", int'(busy), 0);
        start_seq(5'd1, 1'b0, "t7r");
        chk("t7r_first_cnt", int'(power_bus_cnt), 0);
        chk("t7r_first_strobe", int'(power_bus_en), 1);
        wait_done(100, "t7r");
        chk("t7r_strobes", strobes, 2);
        chk("t7r_mask", int'(bus_on_mask), 32'h0003);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
